// File: rtl/shift_sequencer.sv
// N-step shift engine: latches an operand/op/count, applies the 4-bit shifter op once per clock,
// then holds the final word on a valid/ready port until the consumer takes it.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [1:0]       op_reg, op_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // One pass through the mux-based shifter datapath.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] sel);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = d;
      2'b01:   r = {d[WIDTH-2:0], 1'b1};
      2'b10:   r = {1'b1, d[WIDTH-1:1]};
      default: r = {d[0], d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      op_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          data_next  = data_in;
          op_next    = op;
          cnt_next   = count;
          state_next = (count == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        // RUN is only entered with a nonzero count, so the decrement cannot wrap.
        data_next = step(data_reg, op_reg);
        cnt_next  = cnt_reg - 1'b1;
        if (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1})
          state_next = HOLD;
      end
      HOLD: begin
        if (result_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_ready  = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign result_valid = (state_reg == HOLD);
  assign result       = data_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] data_in = 4'd0;
  logic [1:0] op = 2'd0;
  logic [2:0] count = 3'd0;
  logic       busy;
  logic [3:0] result;
  logic       result_valid;
  logic       result_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .data_in(data_in), .op(op), .count(count),
    .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Arithmetic form of the shifter ops.
  function automatic logic [3:0] ref_step(input logic [3:0] d, input logic [1:0] o);
    int v;
    v = int'(d);
    case (o)
      2'd0:    v = v;
      2'd1:    v = ((v * 2) + 1) % 16;
      2'd2:    v = (v / 2) + 8;
      default: v = (v / 2) + ((v % 2) * 8);
    endcase
    return 4'(v);
  endfunction

  // Reference model: on accept, the whole sequence of intermediate words is precomputed.
  logic [3:0] m_val = 4'd0;
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  logic [3:0] pending[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val = 4'd0; m_busy = 1'b0; m_valid = 1'b0;
      pending.delete();
    end else if (!m_busy) begin
      if (start_valid) begin
        logic [3:0] v;
        pending.delete();
        v = data_in;
        for (int k = 0; k < int'(count); k++) begin
          v = ref_step(v, op);
          pending.push_back(v);
        end
        m_val = data_in; m_busy = 1'b1; m_valid = (count == 3'd0);
      end
    end else if (m_valid) begin
      if (result_ready) begin
        m_busy = 1'b0; m_valid = 1'b0;
      end
    end else begin
      m_val = pending.pop_front();
      m_valid = (pending.size() == 0);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_result_valid", int'(result_valid), int'(m_valid));
    check("model_busy", int'(busy), int'(m_busy));
    check("model_start_ready", int'(start_ready), int'(!m_busy));
    if (m_valid || m_busy) check("model_result", int'(result), int'(m_val));
  end

  // Issue one request from IDLE, check literal result and latency, then consume it.
  task automatic run_req(input logic [3:0] d, input logic [1:0] o, input logic [2:0] c,
                         input logic [3:0] exp_res);
    int cycles;
    @(negedge clk);
    check("req_start_ready", int'(start_ready), 1);
    start_valid = 1'b1; data_in = d; op = o; count = c; result_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b0; data_in = 4'($urandom); op = 2'($urandom); count = 3'($urandom);
    cycles = 1;
    while (!result_valid && cycles < 20) begin
      check("req_busy", int'(busy), 1);
      @(negedge clk);
      cycles++;
    end
    check("req_latency", cycles, int'(c) + 1);
    check("req_result", int'(result), int'(exp_res));
    $display("req d=%b op=%b cnt=%0d -> result=%b latency=%0d", d, o, c, result, cycles);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("req_release_valid", int'(result_valid), 0);
    check("req_release_ready", int'(start_ready), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_valid", int'(result_valid), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_start_ready", int'(start_ready), 1);

    run_req(4'b1010, 2'b01, 3'd2, 4'b1011);   // shift left
    run_req(4'b0000, 2'b10, 3'd3, 4'b1110);   // shift right
    run_req(4'b0001, 2'b11, 3'd4, 4'b0001);   // rotate full circle
    run_req(4'b0001, 2'b11, 3'd1, 4'b1000);
    run_req(4'b0110, 2'b01, 3'd0, 4'b0110);   // zero count
    run_req(4'b0101, 2'b00, 3'd5, 4'b0101);   // pass still runs

    // Backpressure: HOLD with new requests pushed at the block.
    @(negedge clk);
    start_valid = 1'b1; data_in = 4'b1010; op = 2'b01; count = 3'd2;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      start_valid = i[0]; data_in = 4'b1111; op = 2'b10; count = 3'd3;
      check("bp_result", int'(result), 4'b1011);
      check("bp_valid", int'(result_valid), 1);
      check("bp_start_ready", int'(start_ready), 0);
      $display("backpressure cycle %0d result=%b valid=%b", i, result, result_valid);
      @(negedge clk);
    end
    start_valid = 1'b0; result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp_release_valid", int'(result_valid), 0);
    check("bp_release_ready", int'(start_ready), 1);
    run_req(4'b0011, 2'b11, 3'd2, 4'b1100);

    // Reset in the middle of a long rotate.
    @(negedge clk);
    start_valid = 1'b1; data_in = 4'b1111; op = 2'b11; count = 3'd7;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_result", int'(result), 0);
    check("rst_mid_valid", int'(result_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    $display("reset mid-run result=%b valid=%b busy=%b", result, result_valid, busy);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_ready", int'(start_ready), 1);
    run_req(4'b1001, 2'b10, 3'd3, 4'b1111);

    // Randomized traffic with random backpressure and stray inputs.
    for (int i = 0; i < 1500; i++) begin
      start_valid = ($urandom_range(0, 2) != 0);
      data_in = 4'($urandom); op = 2'($urandom); count = 3'($urandom);
      result_ready = ($urandom_range(0, 4) < 3);
      @(negedge clk);
      if (result_valid && result_ready)
        $display("random result=%b", result);
    end
    start_valid = 1'b0; result_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("final_idle", int'(start_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
